// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch block
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    assign w_empty   = (r_count == '0);
    assign w_pop     = i_pop && !w_empty;
    // A full buffer only accepts a write when the head leaves in the same cycle.
    assign w_push    = i_push && ((r_count != FULL_COUNT) || w_pop);
    assign w_wr_next = (r_wr == LAST_PTR) ? '0 : r_wr + PTR_W'(1);
    assign w_rd_next = (r_rd == LAST_PTR) ? '0 : r_rd + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= w_wr_next;
            end
            if (w_pop) begin
                r_rd <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Stale entries left behind by a flush are masked so an empty buffer reads as zero.
    assign o_head  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, ROM addressing and fetch buffering
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          SIZE     = 64,
    parameter int          ADDR_W   = $clog2(SIZE),
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;
    logic             w_push;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    assign w_pop  = out_valid && out_ready;
    assign w_push = fetch_en && !redirect_valid && ((w_count < FULL_COUNT) || w_pop);

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = rom_data;

    // Redirect wins over fetch; the target is word-aligned by dropping the low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & ~32'h0000_0003;
        end else if (w_push) begin
            r_pc <= r_pc + 32'(INSTR_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign rom_addr  = r_pc[ADDR_W+1:2];
    assign out_valid = (w_count != '0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks;
    int failures;

    instruction_fetch #(
        .SIZE     (64),
        .ADDR_W   (6),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    assign rom_data = 32'hA000_0000 + {26'd0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_rom_addr", {26'd0, rom_addr}, 32'd0);

        // streaming, one instruction per cycle
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_pc", out_pc, 32'(4 * k));
            check("stream_instr", out_instr, 32'hA000_0000 + 32'(k));
        end

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_instr", out_instr, 32'h0);
        check("async_rst_rom_addr", {26'd0, rom_addr}, 32'd0);

        // backpressure from reset
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_pc", out_pc, 32'h0);
        check("bp_rom_addr", {26'd0, rom_addr}, 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_pc4", out_pc, 32'h4);
        @(negedge clk);
        check("bp_rel_pc8", out_pc, 32'h8);
        check("bp_rel_instr8", out_instr, 32'hA000_0002);
        @(negedge clk);
        check("bp_rel_pc12", out_pc, 32'hC);

        // redirect with full FIFO and pop asserted
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_bubble", {31'd0, out_valid}, 32'd0);
        check("redir_rom_addr", {26'd0, rom_addr}, 32'h10);
        @(negedge clk);
        check("redir_valid", {31'd0, out_valid}, 32'd1);
        check("redir_pc", out_pc, 32'h40);
        check("redir_instr", out_instr, 32'hA000_0010);
        @(negedge clk);
        check("redir_next_pc", out_pc, 32'h44);
        check("redir_next_instr", out_instr, 32'hA000_0011);

        // ROM index wrap past the top of the array
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_00F8;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wrap_bubble", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("wrap_pc_f8", out_pc, 32'hF8);
        check("wrap_instr_f8", out_instr, 32'hA000_003E);
        @(negedge clk);
        check("wrap_pc_fc", out_pc, 32'hFC);
        check("wrap_instr_fc", out_instr, 32'hA000_003F);
        @(negedge clk);
        check("wrap_pc_100", out_pc, 32'h100);
        check("wrap_instr_100", out_instr, 32'hA000_0000);
        check("wrap_rom_addr", {26'd0, rom_addr}, 32'd1);

        // fetch disabled: drain two entries, pc holds, then resume
        out_ready = 1'b0;
        @(negedge clk);
        check("halt_head", out_pc, 32'h100);
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("halt_drain1_valid", {31'd0, out_valid}, 32'd1);
        check("halt_drain1_pc", out_pc, 32'h104);
        @(negedge clk);
        check("halt_empty_valid", {31'd0, out_valid}, 32'd0);
        check("halt_empty_pc", out_pc, 32'h0);
        check("halt_empty_instr", out_instr, 32'h0);
        repeat (2) @(negedge clk);
        check("halt_hold_valid", {31'd0, out_valid}, 32'd0);
        check("halt_hold_rom_addr", {26'd0, rom_addr}, 32'd2);
        fetch_en = 1'b1;
        @(negedge clk);
        check("resume_pc", out_pc, 32'h108);
        check("resume_instr", out_instr, 32'hA000_0002);

        // reset mid-stream, then restart from the reset PC
        #2 rst_n = 1'b0;
        #1;
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_pc", out_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_valid", {31'd0, out_valid}, 32'd1);
        check("restart_pc", out_pc, 32'h0);
        check("restart_instr", out_instr, 32'hA000_0000);
        @(negedge clk);
        check("restart_pc4", out_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
